// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the CPU/DMA memory bus arbiter: FSM state encoding,
// bus owner identifiers and the wait-state counter width.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Wide enough for the largest legal wait-state count (7).
  localparam int CNT_W = 3;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the CPU port, DMA port and memory port signals around the
// arbiter; slave is the arbiter's view, master is the requesters/memory view.
interface mem_bus_arbiter_if #(
  parameter int N  = 16,
  parameter int AW = 8
);

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [N-1:0]  cpu_wdata;
  logic [N-1:0]  cpu_rdata;
  logic          cpu_ack;
  logic          cpu_gnt;

  logic          dma_req;
  logic          dma_we;
  logic [AW-1:0] dma_addr;
  logic [N-1:0]  dma_wdata;
  logic [N-1:0]  dma_rdata;
  logic          dma_ack;
  logic          dma_gnt;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [N-1:0]  mem_wdata;
  logic [N-1:0]  mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata,
    output cpu_rdata, cpu_ack, cpu_gnt,
    output dma_rdata, dma_ack, dma_gnt,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata,
    input  cpu_rdata, cpu_ack, cpu_gnt,
    input  dma_rdata, dma_ack, dma_gnt,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin tie-break: a lone requester wins, and on a tie the
// port that was not served last wins. Output is one-hot {dma, cpu}.
module rr_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic       req_cpu,
  input  logic       req_dma,
  input  owner_e     last,
  output logic [1:0] gnt_oh
);

  // Grant selection from the two requests and the last-served owner.
  always_comb begin
    gnt_oh = 2'b00;
    if (req_cpu && req_dma) begin
      gnt_oh = (last == OWN_CPU) ? 2'b10 : 2'b01;
    end else if (req_cpu) begin
      gnt_oh = 2'b01;
    end else if (req_dma) begin
      gnt_oh = 2'b10;
    end else begin
      gnt_oh = 2'b00;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter for a single-ported memory with WAIT wait states; one
// transaction at a time: accept in IDLE, WAIT+1 cycles of BUSY, ack in DONE.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N    = 16,
  parameter int AW   = 8,
  parameter int WAIT = 1
) (
  input logic              clk,
  input logic              rst,
  mem_bus_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] WAIT_C = CNT_W'(WAIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  owner_e            last_q, last_d;
  owner_e            owner_q, owner_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [N-1:0]      wdata_q, wdata_d;
  logic [N-1:0]      cpu_rdata_q, cpu_rdata_d;
  logic [N-1:0]      dma_rdata_q, dma_rdata_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_gnt_q, cpu_gnt_d;
  logic              dma_gnt_q, dma_gnt_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dma_ack_q, dma_ack_d;
  logic              busy_d;
  logic [1:0]        pick_oh;

  rr_pick2 u_pick (
    .req_cpu (bus.cpu_req),
    .req_dma (bus.dma_req),
    .last    (last_q),
    .gnt_oh  (pick_oh)
  );

  // Next-state, latched transaction and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;

    case (state_q)
      IDLE: begin
        if (pick_oh[0]) begin
          owner_d = OWN_CPU;
          we_d    = bus.cpu_we;
          addr_d  = bus.cpu_addr;
          wdata_d = bus.cpu_wdata;
          cnt_d   = WAIT_C;
          state_d = BUSY;
        end else if (pick_oh[1]) begin
          owner_d = OWN_DMA;
          we_d    = bus.dma_we;
          addr_d  = bus.dma_addr;
          wdata_d = bus.dma_wdata;
          cnt_d   = WAIT_C;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = DONE;
          // Read data is only valid in the final BUSY cycle.
          if (!we_q && owner_q == OWN_CPU) begin
            cpu_rdata_d = bus.mem_rdata;
          end else if (!we_q && owner_q == OWN_DMA) begin
            dma_rdata_d = bus.mem_rdata;
          end else begin
            cpu_rdata_d = cpu_rdata_q;
          end
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d    = (state_d == BUSY);
    mem_en_d  = busy_d;
    mem_we_d  = busy_d && we_d;
    cpu_gnt_d = busy_d && (owner_d == OWN_CPU);
    dma_gnt_d = busy_d && (owner_d == OWN_DMA);
    cpu_ack_d = (state_d == DONE) && (owner_d == OWN_CPU);
    dma_ack_d = (state_d == DONE) && (owner_d == OWN_DMA);
  end

  // State and output registers; reset leaves DMA as last-served so the CPU wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      last_q      <= OWN_DMA;
      owner_q     <= OWN_CPU;
      we_q        <= 1'b0;
      addr_q      <= {AW{1'b0}};
      wdata_q     <= {N{1'b0}};
      cpu_rdata_q <= {N{1'b0}};
      dma_rdata_q <= {N{1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      cpu_gnt_q   <= 1'b0;
      dma_gnt_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      cpu_gnt_q   <= cpu_gnt_d;
      dma_gnt_q   <= dma_gnt_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dma_rdata = dma_rdata_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.dma_ack   = dma_ack_q;
  assign bus.cpu_gnt   = cpu_gnt_q;
  assign bus.dma_gnt   = dma_gnt_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three instances (WAIT=0,1,3) share one stimulus
// stream and are checked every cycle against a transaction-phase model.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0]  cpu_addr, dma_addr;
  logic [15:0] cpu_wdata, dma_wdata, mem_rdata;

  logic        o_en[3], o_we[3], o_cg[3], o_dg[3], o_ca[3], o_da[3];
  logic [7:0]  o_addr[3];
  logic [15:0] o_wd[3], o_crd[3], o_drd[3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_bus_arbiter_if #(.N(16), .AW(8)) bif ();
    mem_bus_arbiter #(.N(16), .AW(8), .WAIT((g == 0) ? 0 : ((g == 1) ? 1 : 3))) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
    );
    assign bif.cpu_req   = cpu_req;
    assign bif.cpu_we    = cpu_we;
    assign bif.cpu_addr  = cpu_addr;
    assign bif.cpu_wdata = cpu_wdata;
    assign bif.dma_req   = dma_req;
    assign bif.dma_we    = dma_we;
    assign bif.dma_addr  = dma_addr;
    assign bif.dma_wdata = dma_wdata;
    assign bif.mem_rdata = mem_rdata;
    assign o_en[g]   = bif.mem_en;
    assign o_we[g]   = bif.mem_we;
    assign o_cg[g]   = bif.cpu_gnt;
    assign o_dg[g]   = bif.dma_gnt;
    assign o_ca[g]   = bif.cpu_ack;
    assign o_da[g]   = bif.dma_ack;
    assign o_addr[g] = bif.mem_addr;
    assign o_wd[g]   = bif.mem_wdata;
    assign o_crd[g]  = bif.cpu_rdata;
    assign o_drd[g]  = bif.dma_rdata;
  end

  // Model: pos = cycles since the accepting edge (0 = idle); owner bit 1 = DMA.
  int          pos[3];
  bit          own[3], last[3], m_we[3];
  logic [7:0]  m_addr[3];
  logic [15:0] m_wd[3], m_crd[3], m_drd[3];

  function automatic int wt(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (WAIT=%0d) observed=%h expected=%h", tag, wt(d), obs, exp);
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      if (rst) begin
        pos[d] = 0; last[d] = 1'b1; own[d] = 1'b0; m_we[d] = 1'b0;
        m_addr[d] = 8'h00; m_wd[d] = 16'h0000; m_crd[d] = 16'h0000; m_drd[d] = 16'h0000;
      end else if (pos[d] == 0) begin
        if (cpu_req || dma_req) begin
          own[d]    = (cpu_req && dma_req) ? !last[d] : dma_req;
          m_we[d]   = own[d] ? dma_we : cpu_we;
          m_addr[d] = own[d] ? dma_addr : cpu_addr;
          m_wd[d]   = own[d] ? dma_wdata : cpu_wdata;
          pos[d]    = 1;
        end
      end else if (pos[d] <= wt(d) + 1) begin
        if (pos[d] == wt(d) + 1 && !m_we[d]) begin
          if (own[d]) m_drd[d] = mem_rdata;
          else        m_crd[d] = mem_rdata;
        end
        pos[d]++;
      end else begin
        last[d] = own[d];
        pos[d]  = 0;
      end
    end
  endtask

  task automatic cycle();
    bit busy, done;
    @(posedge clk);
    model_step();
    #1;
    for (int d = 0; d < 3; d++) begin
      busy = (pos[d] >= 1) && (pos[d] <= wt(d) + 1);
      done = (pos[d] == wt(d) + 2);
      chk("mem_en",    d, o_en[d],   busy);
      chk("mem_we",    d, o_we[d],   busy && m_we[d]);
      chk("cpu_gnt",   d, o_cg[d],   busy && !own[d]);
      chk("dma_gnt",   d, o_dg[d],   busy && own[d]);
      chk("cpu_ack",   d, o_ca[d],   done && !own[d]);
      chk("dma_ack",   d, o_da[d],   done && own[d]);
      chk("mem_addr",  d, o_addr[d], m_addr[d]);
      chk("mem_wdata", d, o_wd[d],   m_wd[d]);
      chk("cpu_rdata", d, o_crd[d],  m_crd[d]);
      chk("dma_rdata", d, o_drd[d],  m_drd[d]);
    end
  endtask

  initial begin
    int ack_at, en_cnt, nack;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 16'h0000;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 8'h00; dma_wdata = 16'h0000;
    mem_rdata = 16'h0000;
    rst = 1'b1;
    cycle(); cycle();

    // CPU read on WAIT=1: two mem_en cycles, ack in the 4th cycle counting the request cycle.
    rst = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10; mem_rdata = 16'hBEEF;
    ack_at = 0; en_cnt = 0;
    for (int k = 2; k <= 9; k++) begin
      cycle();
      if (o_en[1]) en_cnt++;
      if (o_ca[1] && ack_at == 0) begin ack_at = k; cpu_req = 1'b0; end
    end
    chk("rd_ack_cycle", 1, ack_at, 4);
    chk("rd_en_cycles", 1, en_cnt, 2);
    chk("rd_cpu_rdata", 1, o_crd[1], 16'hBEEF);
    chk("rd_dma_rdata", 1, o_drd[1], 16'h0000);
    cpu_req = 1'b0;

    // DMA write on WAIT=0: a single strobe carrying the latched address and data.
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 8'h3F; dma_wdata = 16'h1234;
    en_cnt = 0;
    for (int k = 2; k <= 9; k++) begin
      cycle();
      if (o_en[0]) begin
        en_cnt++;
        chk("wr_we",    0, o_we[0],   1'b1);
        chk("wr_addr",  0, o_addr[0], 8'h3F);
        chk("wr_wdata", 0, o_wd[0],   16'h1234);
      end
      if (o_da[0]) dma_req = 1'b0;
    end
    chk("wr_en_cycles", 0, en_cnt, 1);
    chk("wr_dma_rdata", 0, o_drd[0], 16'h0000);
    dma_req = 1'b0; dma_we = 1'b0;

    // Address change after latching must not reach the memory port.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    for (int k = 2; k <= 10; k++) begin
      cycle();
      if (k == 2) cpu_addr = 8'h20;
      if (o_en[1]) chk("addr_hold", 1, o_addr[1], 8'h10);
      if (o_ca[1]) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
    for (int k = 0; k < 6; k++) cycle();

    // Reset in the 2nd BUSY cycle of WAIT=3, then a request right after reset.
    cpu_req = 1'b1; cpu_addr = 8'h55;
    cycle(); cycle();
    rst = 1'b1;
    cycle();
    chk("rst_mem_en",  2, o_en[2],   1'b0);
    chk("rst_cpu_gnt", 2, o_cg[2],   1'b0);
    chk("rst_cpu_ack", 2, o_ca[2],   1'b0);
    chk("rst_addr",    2, o_addr[2], 8'h00);
    chk("rst_rdata",   2, o_crd[2],  16'h0000);
    rst = 1'b0;
    cycle();
    chk("post_rst_en",  2, o_en[2], 1'b1);
    chk("post_rst_gnt", 2, o_cg[2], 1'b1);
    cpu_req = 1'b0;
    for (int k = 0; k < 8; k++) cycle();

    // Continuous requests from both ports after reset: acks alternate CPU, DMA, ...
    rst = 1'b1;
    cycle();
    rst = 1'b0; cpu_req = 1'b1; dma_req = 1'b1;
    nack = 0;
    for (int k = 1; k <= 40; k++) begin
      cpu_addr = 8'($urandom); dma_addr = 8'($urandom);
      cpu_we = 1'($urandom); dma_we = 1'($urandom);
      mem_rdata = 16'($urandom);
      cycle();
      if (o_ca[1] || o_da[1]) begin
        chk("rr_order", 1, o_da[1], nack % 2);
        nack++;
      end
    end
    chk("rr_ack_count", 1, nack, 10);

    // Random traffic with occasional resets.
    for (int k = 0; k < 2500; k++) begin
      cpu_req = ($urandom_range(0, 9) < 6); dma_req = ($urandom_range(0, 9) < 5);
      cpu_we = 1'($urandom); dma_we = 1'($urandom);
      cpu_addr = 8'($urandom); dma_addr = 8'($urandom);
      cpu_wdata = 16'($urandom); dma_wdata = 16'($urandom);
      mem_rdata = 16'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 16: data width.
REQ-002 The block SHALL have parameter AW, default 8: address width.
REQ-003 The block SHALL have parameter WAIT, default 1: memory wait states, legal range 0..7.
REQ-004 The block SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have ports cpu_req, cpu_we, dma_req and dma_we, input, 1 bit each: request and write-enable, CPU and DMA ports.
REQ-007 The block SHALL have ports cpu_addr and dma_addr, input, AW bits: request address.
REQ-008 The block SHALL have ports cpu_wdata and dma_wdata, input, N bits: write data.
REQ-009 The block SHALL have ports cpu_rdata and dma_rdata, output, N bits: registered read data.
REQ-010 The block SHALL have ports cpu_ack and dma_ack, output, 1 bit each: one-cycle completion pulse.
REQ-011 The block SHALL have ports cpu_gnt and dma_gnt, output, 1 bit each: high while that port owns the bus (CPU stall source).
REQ-012 The block SHALL have ports mem_en and mem_we, output, 1 bit each: memory enable and write strobe.
REQ-013 The block SHALL have port mem_addr, output, AW bits, and port mem_wdata, output, N bits: memory address and write data.
REQ-014 The block SHALL have port mem_rdata, input, N bits: memory read data, valid in the last BUSY cycle.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY, DONE.
REQ-016 In IDLE with any req high, the block SHALL pick an owner and latch owner, we, addr and wdata, load cnt=WAIT, and go to BUSY.
REQ-017 In IDLE with no req, the block SHALL stay in IDLE.
REQ-018 If only one port requests, that port SHALL be granted.
REQ-019 If both ports request, the port not served last SHALL be granted (round-robin).
REQ-020 In BUSY, mem_en SHALL be 1 and mem_we/mem_addr/mem_wdata SHALL equal the latched values; the owner's gnt SHALL be 1.
REQ-021 In BUSY with cnt>0, cnt SHALL decrement; with cnt==0, the block SHALL go to DONE, and on a read SHALL capture mem_rdata into the owner's rdata register.
REQ-022 BUSY SHALL last exactly WAIT+1 cycles.
REQ-023 In DONE, the owner's ack SHALL be 1 for exactly one cycle, last-served SHALL be updated to the owner, and the next state SHALL be IDLE.
REQ-024 Transaction length SHALL be WAIT+3 cycles: 1 IDLE + (WAIT+1) BUSY + 1 DONE; at most one transaction is outstanding.
REQ-025 A requester SHALL hold req and payload stable until ack; the block SHALL ignore payload changes after latching.
REQ-026 If req is withdrawn during BUSY, the transaction SHALL still complete and ack SHALL still pulse.
REQ-027 On a write, the owner's rdata SHALL be unchanged; the non-owner's rdata SHALL never change.
REQ-028 Outside BUSY: mem_en=0, mem_we=0, both gnt=0; mem_addr and mem_wdata hold their last latched values.
REQ-029 The two ack outputs SHALL never be high together, and the two gnt outputs SHALL never be high together.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL enter IDLE and set cnt=0, last-served=DMA (so the CPU wins the first tie), all ack/gnt/mem_en/mem_we=0, and mem_addr, mem_wdata, cpu_rdata and dma_rdata to 0.
REQ-031 Reset asserted mid-transaction SHALL abort it without an ack.
REQ-032 A request present in the first cycle after reset SHALL be accepted from IDLE normally.

Structure
REQ-033 The state encoding (IDLE/BUSY/DONE) and the owner constants OWN_CPU/OWN_DMA SHALL live in the shared package.
REQ-034 The tie-break logic SHALL be one sub-module, rr_pick2: inputs two reqs and last-served; output grant-one-hot; purely combinational.
REQ-035 The FSM, wait counter and registers SHALL reside in mem_bus_arbiter.

Verification
REQ-036 WAIT=1; CPU read addr 0x10 with mem_rdata=0xBEEF -> mem_en high 2 cycles, cpu_ack 4 cycles after req, cpu_rdata=0xBEEF, dma_rdata=0.
REQ-037 Both ports request continuously after reset -> grants alternate CPU, DMA, CPU, DMA; acks never overlap.
REQ-038 WAIT=0; DMA write addr 0x3F data 0x1234 -> one mem_en cycle with mem_we=1, mem_addr=0x3F, mem_wdata=0x1234; dma_rdata unchanged.
REQ-039 rst asserted in the 2nd BUSY cycle with WAIT=3 -> next cycle IDLE, no ack, all outputs 0.
REQ-040 CPU changes cpu_addr from 0x10 to 0x20 during BUSY -> mem_addr stays 0x10 until ack.
